// File: rtl/window_scan_controller_pkg.sv
// Shared types and sizing helpers for the 15x15 window scan controller.
// Default geometry matches the 17x17 image / 15x15 kernel configuration.
package window_scan_controller_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    EMIT = 2'd2,
    LAST = 2'd3
  } scan_state_t;

  localparam int unsigned DEF_COLS = 17;
  localparam int unsigned DEF_ROWS = 17;
  localparam int unsigned DEF_K    = 15;

  // Counter width for an index range 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned num_windows(input int unsigned cols,
                                              input int unsigned rows,
                                              input int unsigned k);
    return (rows - k + 1) * (cols - k + 1);
  endfunction

  localparam int unsigned COL_W       = cnt_w(DEF_COLS);
  localparam int unsigned ROW_W       = cnt_w(DEF_ROWS);
  localparam int unsigned NUM_WINDOWS = num_windows(DEF_COLS, DEF_ROWS, DEF_K);

endpackage

// File: rtl/window_scan_controller_scan_counter.sv
// Enabled wrap-around counter 0..MAX with synchronous clear and terminal-count flag.
// Used for both the column and the output-row position of the scan.
module window_scan_controller_scan_counter
  import window_scan_controller_pkg::*;
#(
  parameter int unsigned WIDTH = COL_W,
  parameter int unsigned MAX   = DEF_COLS - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             term_c
);

  assign term_c = (count == WIDTH'(MAX));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= term_c ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/window_scan_controller.sv
// Sequences columns into the sliding-window buffer and flags fully populated windows.
// Window flag and coordinates are registered to line up with the buffer's registered outputs.
module window_scan_controller
  import window_scan_controller_pkg::*;
#(
  parameter int unsigned COLS = DEF_COLS,
  parameter int unsigned ROWS = DEF_ROWS,
  parameter int unsigned K    = DEF_K
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     done_i,
  output logic                     shift_en_o,
  output logic                     done_o,
  output logic [cnt_w(ROWS)-1:0]   row_o,
  output logic [cnt_w(COLS)-1:0]   col_o,
  output logic                     progress_done_o,
  output logic                     busy_o
);

  localparam int unsigned CW = cnt_w(COLS);
  localparam int unsigned RW = cnt_w(ROWS);

  scan_state_t   state;
  scan_state_t   state_nx;
  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  logic          col_term_c;
  logic          row_term_c;
  logic          accept_c;
  logic          window_c;
  logic          row_en_c;
  logic          clr_c;

  window_scan_controller_scan_counter #(
    .WIDTH (CW),
    .MAX   (COLS - 1)
  ) u_col_counter (
    .clk    (clk),
    .rst    (rst),
    .en     (accept_c),
    .clr    (clr_c),
    .count  (col_cnt),
    .term_c (col_term_c)
  );

  window_scan_controller_scan_counter #(
    .WIDTH (RW),
    .MAX   (ROWS - K)
  ) u_row_counter (
    .clk    (clk),
    .rst    (rst),
    .en     (row_en_c),
    .clr    (clr_c),
    .count  (row_cnt),
    .term_c (row_term_c)
  );

  // Accept decode and next-state; the column index being accepted decides the window flag.
  always_comb begin
    accept_c = 1'b0;
    window_c = 1'b0;
    row_en_c = 1'b0;
    clr_c    = 1'b0;
    state_nx = state;

    accept_c = done_i && (state != LAST);
    window_c = accept_c && ((32'(col_cnt) + 32'd1) >= K);
    row_en_c = accept_c && col_term_c;
    clr_c    = (state == LAST);

    case (state)
      IDLE, FILL, EMIT: begin
        if (accept_c) begin
          if (col_term_c && row_term_c) begin
            state_nx = LAST;
          end else if (col_term_c) begin
            state_nx = (K == 32'd1) ? EMIT : FILL;
          end else if ((32'(col_cnt) + 32'd2) >= K) begin
            state_nx = EMIT;
          end else begin
            state_nx = FILL;
          end
        end
      end
      LAST:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Shift enable is combinational so the buffer shifts on the same edge the column is counted.
  assign shift_en_o = accept_c && rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      done_o          <= 1'b0;
      row_o           <= '0;
      col_o           <= '0;
      progress_done_o <= 1'b0;
      busy_o          <= 1'b0;
    end else begin
      state           <= state_nx;
      done_o          <= window_c;
      progress_done_o <= (state == LAST);
      busy_o          <= (state_nx != IDLE);
      if (window_c) begin
        row_o <= row_cnt;
        col_o <= col_cnt;
      end
    end
  end

endmodule

// File: tb/tb_window_scan_controller.sv
// Directed bench for window_scan_controller: a reference model pushes expected windows
// into a queue as columns are driven; a negedge monitor pops and compares them.
module tb_window_scan_controller;

  localparam int COLS = 17;
  localparam int ROWS = 17;
  localparam int K    = 15;

  typedef struct {
    int row;
    int col;
  } win_t;

  logic       clk;
  logic       rst;
  logic       done_i;
  logic       shift_en_o;
  logic       done_o;
  logic [4:0] row_o;
  logic [4:0] col_o;
  logic       progress_done_o;
  logic       busy_o;

  logic       done2;
  logic       shift2;
  logic       done2_o;
  logic [3:0] row2;
  logic [3:0] col2;
  logic       prog2;
  logic       busy2;

  int   errors;
  int   checks;
  int   win_cnt;
  int   prog_cnt;
  logic prev_done;
  win_t exp_q[$];
  win_t mon_e;

  // Reference model state: 0 = idle, 1 = filling/emitting, 2 = last
  int   mcol;
  int   mrow;
  int   mstate;

  window_scan_controller dut (
    .clk             (clk),
    .rst             (rst),
    .done_i          (done_i),
    .shift_en_o      (shift_en_o),
    .done_o          (done_o),
    .row_o           (row_o),
    .col_o           (col_o),
    .progress_done_o (progress_done_o),
    .busy_o          (busy_o)
  );

  window_scan_controller #(
    .COLS (15),
    .ROWS (15),
    .K    (15)
  ) dut_k15 (
    .clk             (clk),
    .rst             (rst),
    .done_i          (done2),
    .shift_en_o      (shift2),
    .done_o          (done2_o),
    .row_o           (row2),
    .col_o           (col2),
    .progress_done_o (prog2),
    .busy_o          (busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Window scoreboard and end-of-frame timing, sampled mid-cycle.
  always @(negedge clk) begin
    if (done_o) begin
      win_cnt++;
      check("window_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("win_row", 32'(row_o), 32'(mon_e.row));
        check("win_col", 32'(col_o), 32'(mon_e.col));
      end
    end
    if (progress_done_o) begin
      prog_cnt++;
      check("progress_after_last_window", 32'(prev_done), 32'd1);
      check("progress_no_pending_windows", 32'(exp_q.size()), 32'd0);
    end
    prev_done = done_o;
  end

  // One clock of stimulus; called at posedge+1, returns at the following posedge+1.
  task automatic step(input logic d);
    logic exp_shift;
    logic exp_win;
    logic exp_prog;
    win_t w;
    done_i = d;
    #1;
    exp_shift = d && (mstate != 2);
    check("shift_en", 32'(shift_en_o), 32'(exp_shift));
    exp_win  = exp_shift && (mcol >= K - 1);
    exp_prog = (mstate == 2);
    if (exp_win) begin
      w.row = mrow;
      w.col = mcol;
      exp_q.push_back(w);
    end
    if (mstate == 2) begin
      mstate = 0;
    end else if (exp_shift) begin
      mstate = 1;
      if (mcol == COLS - 1) begin
        mcol = 0;
        if (mrow == ROWS - K) begin
          mrow   = 0;
          mstate = 2;
        end else begin
          mrow++;
        end
      end else begin
        mcol++;
      end
    end
    @(posedge clk);
    #1;
    check("done_o", 32'(done_o), 32'(exp_win));
    check("progress_done", 32'(progress_done_o), 32'(exp_prog));
    check("busy", 32'(busy_o), 32'(mstate != 0));
  endtask

  task automatic run(input int n, input logic d);
    for (int i = 0; i < n; i++) step(d);
  endtask

  task automatic frame_check(input string tag, input int w0, input int p0,
                             input int nwin, input int nprog);
    check({tag, "_windows"}, 32'(win_cnt - w0), 32'(nwin));
    check({tag, "_progress"}, 32'(prog_cnt - p0), 32'(nprog));
    check({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int w0;
    int p0;
    errors    = 0;
    checks    = 0;
    win_cnt   = 0;
    prog_cnt  = 0;
    prev_done = 1'b0;
    mcol      = 0;
    mrow      = 0;
    mstate    = 0;
    rst       = 1'b0;
    done_i    = 1'b1;
    done2     = 1'b0;

    // Reset values, with a column presented during reset
    #1;
    check("rst_shift_en", 32'(shift_en_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_row", 32'(row_o), 32'd0);
    check("rst_col", 32'(col_o), 32'd0);
    check("rst_progress", 32'(progress_done_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    done_i = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;

    // Continuous stream; one column held high into LAST is dropped
    w0 = win_cnt; p0 = prog_cnt;
    run(51, 1'b1);
    step(1'b1);
    step(1'b0);
    frame_check("continuous", w0, p0, 9, 1);

    // Stall of four cycles at column 15 of row 1
    w0 = win_cnt; p0 = prog_cnt;
    run(32, 1'b1);
    run(4, 1'b0);
    run(19, 1'b1);
    run(2, 1'b0);
    frame_check("stall", w0, p0, 9, 1);

    // Reset asserted mid-row 1, after window (0,16) was reported
    run(25, 1'b1);
    done_i = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("midrst_done", 32'(done_o), 32'd0);
    check("midrst_row", 32'(row_o), 32'd0);
    check("midrst_col", 32'(col_o), 32'd0);
    check("midrst_progress", 32'(progress_done_o), 32'd0);
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_shift_en", 32'(shift_en_o), 32'd0);
    exp_q.delete();
    mcol = 0; mrow = 0; mstate = 0;
    #4 rst = 1'b1;
    @(posedge clk);
    #1;
    w0 = win_cnt; p0 = prog_cnt;
    run(51, 1'b1);
    run(2, 1'b0);
    frame_check("after_reset", w0, p0, 9, 1);

    // Back-to-back frames with a single idle gap
    w0 = win_cnt; p0 = prog_cnt;
    run(51, 1'b1);
    run(2, 1'b0);
    run(51, 1'b1);
    run(2, 1'b0);
    frame_check("back_to_back", w0, p0, 18, 2);

    // K = COLS = ROWS = 15: exactly one window, progress one cycle later
    for (int i = 0; i < 15; i++) begin
      done2 = 1'b1;
      #1;
      check("k15_shift_en", 32'(shift2), 32'd1);
      @(posedge clk);
      #1;
      check("k15_done", 32'(done2_o), 32'(i == 14));
      check("k15_busy", 32'(busy2), 32'd1);
      if (i == 14) begin
        check("k15_row", 32'(row2), 32'd0);
        check("k15_col", 32'(col2), 32'd14);
      end
    end
    done2 = 1'b0;
    @(posedge clk);
    #1;
    check("k15_progress", 32'(prog2), 32'd1);
    check("k15_done_after", 32'(done2_o), 32'd0);
    check("k15_busy_after", 32'(busy2), 32'd0);
    @(posedge clk);
    #1;
    check("k15_progress_single", 32'(prog2), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
